// File: rtl/serial_twos_comp_ctrl_if.sv
// Word-level handshakes of the serial two's-complement controller:
// operand in (valid/ready) and reassembled result out (valid/ready).
interface serial_twos_comp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/serial_twos_comp_ctrl.sv
// Parallel <-> serial wrapper around the serial two's-complementer: clears it,
// streams the operand LSB-first, and reassembles the returned serial result.
module serial_twos_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_b,
  serial_twos_comp_ctrl_if.slave   bus,
  output logic                     comp_clr_b,
  output logic                     stream,
  input  logic                     twos_comp
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] tx, rx;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = bus.in_valid ? CLEAR : IDLE;
      CLEAR:   nxt = SHIFT;
      SHIFT:   nxt = (cnt == CW'(WIDTH - 1)) ? DRAIN : SHIFT;
      DRAIN:   nxt = DONE;
      DONE:    nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    stream        = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      SHIFT:   stream        = tx[0];
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_data = rx;

  // The complementer's output lags stream by one cycle, so result bit k-1 is
  // captured during SHIFT step k and the last bit during DRAIN.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx         <= '0;
      rx         <= '0;
      cnt        <= '0;
      comp_clr_b <= 1'b1;
    end else begin
      comp_clr_b <= (nxt != CLEAR);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            tx  <= bus.in_data;
            cnt <= '0;
          end
        end
        SHIFT: begin
          tx  <= {1'b0, tx[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt != '0) rx <= {twos_comp, rx[WIDTH-1:1]};
        end
        DRAIN:   rx <= {twos_comp, rx[WIDTH-1:1]};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_twos_comp_ctrl.sv
// Bench: controller plus a behavioural Moore serial complementer on a shared
// clock; directed words, stall, back-to-back stream and mid-word reset.
module tb_serial_twos_comp_ctrl;
  localparam int W = 8;

  logic clk, rst_b;
  logic comp_clr_b, stream, twos_comp;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;

  serial_twos_comp_ctrl_if #(.WIDTH(W)) bus ();

  serial_twos_comp_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bus        (bus),
    .comp_clr_b (comp_clr_b),
    .stream     (stream),
    .twos_comp  (twos_comp)
  );

  // Serial complementer: copy bits up to and including the first 1, invert after.
  logic [1:0] cs;
  wire comp_rst_n = rst_b & comp_clr_b;
  always_ff @(posedge clk or negedge comp_rst_n) begin
    if (!comp_rst_n) cs <= 2'd0;
    else if (cs == 2'd0) cs <= stream ? 2'd1 : 2'd0;
    else cs <= stream ? 2'd2 : 2'd3;
  end
  assign twos_comp = (cs == 2'd1) || (cs == 2'd3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic       clr_tr [0:8191];
  logic       str_tr [0:8191];
  logic [7:0] acc_d[$], out_d[$];
  int         acc_c[$], out_c[$];

  always @(negedge clk) begin
    if (cyc < 8192) begin
      clr_tr[cyc] = comp_clr_b;
      str_tr[cyc] = stream;
    end
    if (rst_b && bus.in_valid && bus.in_ready) begin
      acc_d.push_back(bus.in_data);
      acc_c.push_back(cyc);
    end
    if (rst_b && bus.out_valid && bus.out_ready) begin
      out_d.push_back(bus.out_data);
      out_c.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] x);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [7:0] d);
    bit ok = 0;
    d = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; d = bus.out_data; break; end
    end
    if (!ok) chk("out_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  logic [7:0] dv [5] = '{8'h01, 8'h00, 8'h80, 8'h6C, 8'hFF};
  logic [7:0] de [5] = '{8'hFF, 8'h00, 8'h80, 8'h94, 8'h01};
  logic [7:0] rv [100];

  initial begin
    logic [7:0]  d, e;
    logic [11:0] clrv, strv;
    int          a, na, no;
    bit          ok;

    rst_b = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_stream",    stream,        0);
    chk("rst_clr_b",     comp_clr_b,    1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(dv[i]);
      wait_out(d);
      e = ~dv[i] + 8'd1;
      chk("dir_table", d, de[i]);
      chk("dir_model", d, e);
      chk("dir_latency", out_c[out_c.size()-1] - acc_c[acc_c.size()-1] - 1, 10);
      if (i == 0) begin
        a = acc_c[acc_c.size()-1];
        for (int j = 0; j < 12; j++) begin
          clrv[j] = clr_tr[a+j];
          strv[j] = str_tr[a+j];
        end
        chk("clr_pulse",  clrv, 12'hFFD);
        chk("stream_seq", strv, 12'h004);
      end
      @(negedge clk);
      chk("dir_idle_ready", bus.in_ready, 1);
      @(posedge clk); #1;
    end

    // Consumer stall with a competing operand offered during DONE.
    na = acc_d.size();
    bus.out_ready = 1'b0;
    send(8'h25);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    chk("stall_reach_done", ok, 1);
    chk("stall_first_data", bus.out_data, 8'hDB);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid",    bus.out_valid, 1);
      chk("stall_data",     bus.out_data,  8'hDB);
      chk("stall_in_ready", bus.in_ready,  0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_in_ready",  bus.in_ready,  1);
    chk("post_hs_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("stall_acc_count", acc_d.size() - na, 2);
    if (acc_d.size() >= 2) begin
      chk("stall_acc_first",  acc_d[acc_d.size()-2], 8'h25);
      chk("stall_acc_second", acc_d[acc_d.size()-1], 8'h33);
    end
    if (acc_c.size() > 0 && out_c.size() > 0)
      chk("stall_accept_gap", acc_c[acc_c.size()-1] - out_c[out_c.size()-1], 1);
    wait_out(d);
    chk("stall_second_res", d, 8'hCD);

    // Back-to-back stream with the consumer always ready.
    na = acc_d.size();
    no = out_d.size();
    for (int i = 0; i < 100; i++) begin
      rv[i] = 8'($urandom);
      bus.in_data  = rv[i];
      bus.in_valid = 1'b1;
      ok = 0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (bus.in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("b2b_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("b2b_acc_count", acc_d.size() - na, 100);
    chk("b2b_out_count", out_d.size() - no, 100);
    for (int i = 0; i < 100; i++) begin
      if (no + i < out_d.size()) begin
        e = ~rv[i] + 8'd1;
        chk("b2b_result", out_d[no+i], e);
      end
      if (i > 0 && na + i < acc_c.size())
        chk("b2b_period", acc_c[na+i] - acc_c[na+i-1], 12);
    end

    // Reset pulse at SHIFT bit 3 of 8'h5A.
    no = out_d.size();
    send(8'h5A);
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_stream_bit3", stream, 1);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready",  bus.in_ready,  1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data",  bus.out_data,  0);
    chk("mid_rst_stream",    stream,        0);
    chk("mid_rst_clr_b",     comp_clr_b,    1);
    repeat (2) @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (15) @(posedge clk); #1;
    chk("mid_rst_no_output", out_d.size() - no, 0);
    send(8'h03);
    wait_out(d);
    chk("after_rst_res", d, 8'hFD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_twos_comp_ctrl.md
# serial_twos_comp_ctrl

Word-level front/back end for the serial two's-complementer. Accepts a parallel operand over a valid/ready handshake and clears the complementer before each word. Drives the operand LSB-first onto the complementer's `stream` input, collects the returned serial `twos_comp` bits and presents the reassembled word over a second valid/ready handshake. It is the transmitter and receiver wrapped around the serial complementer FSM, so that block can be used on parallel datapaths.

## Interface
- `WIDTH`, 8: operand/result width in bits (≥2).

- `clk`  in  1  clock; all flops rising-edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept operand (high only in IDLE).
- `in_data`  in  WIDTH  operand, sampled on `in_valid && in_ready`.
- `comp_clr_b`  out  1  active-low clear to complementer's reset; registered output, glitch-free.
- `stream`  out  1  serial operand bit to complementer, LSB first.
- `twos_comp`  in  1  serial result bit from complementer (Moore: bit k valid the cycle after `stream` bit k).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  WIDTH  result word, stable while `out_valid`.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE: `in_ready`=1. On `in_valid`, load `in_data` into the TX shift register, clear the bit counter and go to CLEAR.
- CLEAR: one cycle, `comp_clr_b`=0 (registered, so low exactly this cycle), `stream`=0. Then go to SHIFT.
- SHIFT: `WIDTH` cycles, counter k=0..WIDTH-1.
  - `stream` = TX[0], and TX shifts right each cycle.
  - For k≥1, capture `twos_comp` as result bit k-1: RX <= {twos_comp, RX[WIDTH-1:1]}.
  - After k=WIDTH-1, go to DRAIN.
- DRAIN: one cycle, `stream`=0. Capture final bit WIDTH-1 the same way. Go to DONE.
- DONE: `out_valid`=1, `out_data`=RX. Hold until `out_ready`, then go to IDLE.
- Outside SHIFT, `stream`=0. Outside CLEAR, `comp_clr_b`=1.
- Counter width `$clog2(WIDTH+1)` and wraps nowhere. Illegal state encodings go to IDLE with outputs at reset values.
- Arithmetic: `out_data` = (~`in_data` + 1) mod 2^WIDTH, as produced by the attached complementer. The block itself performs no arithmetic; it only sequences and reassembles.
- `in_valid` while not IDLE is ignored (`in_ready`=0). `out_ready` outside DONE is ignored.

## Timing
- Reset (async assert, sync-released flops): state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `stream`=0, `comp_clr_b`=1, TX/RX/counter=0.
- Acceptance edge E0. CLEAR in cycle E0+1. SHIFT bits 0..WIDTH-1 in cycles E0+2..E0+WIDTH+1. DRAIN in E0+WIDTH+2. `out_valid` rises at E0+WIDTH+3.
  - Latency: WIDTH+2 cycles from acceptance to `out_valid` (10 for WIDTH=8).
- Handshake completes on the edge where `out_valid && out_ready`. `in_ready` is high the next cycle. Minimum word period: WIDTH+4 cycles; no back-to-back overlap.
- `out_ready` held high before DONE: result leaves after exactly one DONE cycle.
- `rst_b` asserted mid-operation (any state) aborts immediately to reset values. The partial word is discarded and no `out_valid` is issued. The complementer is re-cleared by the next word's CLEAR.
- `comp_clr_b` low pulse is exactly one cycle, and TX bit 0 is driven only after it is released, so the complementer always starts each word in its idle state.

## Test plan
Bench instantiates this block with the serial complementer FSM, both on `clk`/`rst_b`, with `comp_clr_b` ANDed into the complementer's reset.
- WIDTH=8, `in_data`=8'h01 -> `out_data`=8'hFF, `out_valid` exactly 10 cycles after acceptance. `comp_clr_b` low one cycle; `stream` sequence 1,0,0,0,0,0,0,0.
- 8'h00 -> 8'h00; 8'h80 -> 8'h80; 8'h6C -> 8'h94; 8'hFF -> 8'h01; all checked against (~x+1)&8'hFF.
- `out_ready`=0 for 5 cycles in DONE -> `out_valid` and `out_data` stable; `in_ready`=0 and a second `in_valid` is ignored. Release -> second word accepted the cycle after the handshake and correct.
- `out_ready` tied high, 100 random back-to-back operands -> every result correct, period 12 cycles, no dropped or duplicated words.
- `rst_b` pulsed low at SHIFT bit 3 of 8'h5A -> all outputs at reset values during reset, no `out_valid`. Next word 8'h03 -> 8'hFD.
